// File: rtl/vproc_pkg.sv
// vproc_pkg: shared types and helpers for the vector processor register file.
//   vrf_state_e  - register file sequencer state (INIT sweep / READY)
//   vreg_addr_w  - word address width for a given register geometry
//   vrf_lb_col   - loopback column index inside a bank for a write port
package vproc_pkg;

  typedef enum logic {VRF_INIT, VRF_READY} vrf_state_e;

  // Address width of the flat word space: VREG_CNT registers of
  // VREG_W/PORT_W words each.
  function automatic int unsigned vreg_addr_w(int unsigned vreg_w,
                                              int unsigned port_w,
                                              int unsigned vreg_cnt);
    return $clog2(vreg_cnt * (vreg_w / port_w));
  endfunction

  // A bank owns one loopback column per *other* write port. Columns are
  // numbered in write-port order with the bank's own port skipped.
  function automatic int unsigned vrf_lb_col(int unsigned bank,
                                             int unsigned port);
    return (port < bank) ? port : port - 1;
  endfunction

endpackage

// File: rtl/vproc_vregfile_bank.sv
// vproc_vregfile_bank: one bank row of the XOR-banked register file.
// Single write port, N_RD asynchronous read columns, byte-enabled.
// A raw-write mux lets the init sequencer overwrite a full word
// directly, bypassing the normal byte-enabled write port.
// Ports:
//   clk_i       clock
//   we_be_i     byte enables of the normal write (all zero = no write)
//   waddr_i     normal write word address
//   wdata_i     normal write data (already XOR-composed by the caller)
//   raw_we_i    raw write: takes priority, writes all bytes
//   raw_addr_i  raw write address
//   raw_data_i  raw write data
//   raddr_i     read column addresses
//   rdata_o     read column data (combinational)
module vproc_vregfile_bank #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned PORT_W = 32,
  parameter int unsigned N_RD   = 5,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned NB    = PORT_W / 8
) (
  input  logic              clk_i,
  input  logic [NB-1:0]     we_be_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [PORT_W-1:0] wdata_i,
  input  logic              raw_we_i,
  input  logic [AW-1:0]     raw_addr_i,
  input  logic [PORT_W-1:0] raw_data_i,
  input  logic [AW-1:0]     raddr_i [N_RD],
  output logic [PORT_W-1:0] rdata_o [N_RD]
);

  // Storage is intentionally not reset; the init sweep clears it.
  logic [PORT_W-1:0] mem_q [DEPTH];

  logic [NB-1:0]     be;
  logic [AW-1:0]     addr;
  logic [PORT_W-1:0] data;

  always_comb begin
    be   = we_be_i;
    addr = waddr_i;
    data = wdata_i;
    if (raw_we_i) begin
      be   = '1;
      addr = raw_addr_i;
      data = raw_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (be[k]) mem_q[addr][k*8 +: 8] <= data[k*8 +: 8];
    end
  end

  always_comb begin
    for (int i = 0; i < N_RD; i++) rdata_o[i] = mem_q[raddr_i[i]];
  end

endmodule

// File: rtl/vproc_vregfile_mp.sv
// vproc_vregfile_mp: multi-ported vector register file, XOR-banked.
// Each write port owns a bank; the logical word at an address is the XOR
// of all banks at that address. A write to bank p stores data XOR the
// other banks' current words, so the XOR of all banks equals the data.
// Optional macro: VPROC_VREGFILE_FWD_EN enables write-to-read bypass.
// Ports:
//   clk_i, async_rst_ni  clock, asynchronous active-low reset
//   clear_i              pulse: re-run the zeroing sweep
//   ready_o              high once the sweep is done; writes accepted
//   wr_addr_i/data_i/be_i/we_i  per write port; higher port wins bytes
//   wr_coll_o            per port, registered: bytes masked by higher port
//   rd_addr_i/rd_data_o  read ports, one cycle latency
// Handshake: there is no backpressure. A write is accepted on any edge
// where ready_o is high and wr_we_i is set; reads always complete and
// rd_data_o reflects the address presented before the previous edge.
module vproc_vregfile_mp
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned PORT_W   = 32,
  parameter int unsigned VREG_CNT = 32,
  parameter int unsigned PORTS_RD = 4,
  parameter int unsigned PORTS_WR = 2,
  localparam int unsigned WPR     = VREG_W / PORT_W,
  localparam int unsigned DEPTH   = VREG_CNT * WPR,
  localparam int unsigned AW      = vreg_addr_w(VREG_W, PORT_W, VREG_CNT),
  localparam int unsigned NB      = PORT_W / 8
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic                clear_i,
  output logic                ready_o,
  input  logic [AW-1:0]       wr_addr_i [PORTS_WR],
  input  logic [PORT_W-1:0]   wr_data_i [PORTS_WR],
  input  logic [NB-1:0]       wr_be_i   [PORTS_WR],
  input  logic [PORTS_WR-1:0] wr_we_i,
  output logic [PORTS_WR-1:0] wr_coll_o,
  input  logic [AW-1:0]       rd_addr_i [PORTS_RD],
  output logic [PORT_W-1:0]   rd_data_o [PORTS_RD]
);

  localparam int unsigned NCOL = PORTS_RD + PORTS_WR - 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  vrf_state_e          state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [PORTS_WR-1:0] coll_q, coll_d;
  logic [PORT_W-1:0]   rd_q [PORTS_RD];
  logic [PORT_W-1:0]   rd_d [PORTS_RD];

  logic                in_ready;
  logic [NB-1:0]       be_eff     [PORTS_WR];
  logic [PORT_W-1:0]   bank_wdata [PORTS_WR];
  logic [PORT_W-1:0]   col_data   [PORTS_WR][NCOL];

  assign in_ready = (state_q == VRF_READY);

  // Byte arbitration: a byte requested by a higher port at the same
  // address is removed from every lower port, so each byte of an address
  // has at most one writer per cycle and the XOR banking stays coherent.
  always_comb begin
    for (int p = 0; p < PORTS_WR; p++) begin
      be_eff[p] = (in_ready && wr_we_i[p]) ? wr_be_i[p] : '0;
      coll_d[p] = 1'b0;
      for (int q = p + 1; q < PORTS_WR; q++) begin
        if (wr_we_i[q] && (wr_addr_i[q] == wr_addr_i[p])) begin
          coll_d[p] = coll_d[p] | (|(be_eff[p] & wr_be_i[q]));
          be_eff[p] = be_eff[p] & ~wr_be_i[q];
        end
      end
    end
  end

  // Loopback composition: new bank word = data ^ every other bank's word.
  always_comb begin
    for (int p = 0; p < PORTS_WR; p++) begin
      bank_wdata[p] = wr_data_i[p];
      for (int q = 0; q < PORTS_WR; q++) begin
        if (q != p) begin
          bank_wdata[p] = bank_wdata[p] ^ col_data[q][PORTS_RD + vrf_lb_col(q, p)];
        end
      end
    end
  end

  // Read composition, sampled into rd_q at the edge.
  always_comb begin
    for (int i = 0; i < PORTS_RD; i++) begin
      rd_d[i] = '0;
      for (int b = 0; b < PORTS_WR; b++) rd_d[i] = rd_d[i] ^ col_data[b][i];
`ifdef VPROC_VREGFILE_FWD_EN
      // be_eff is exclusive per byte, so at most one port matches a byte.
      for (int p = 0; p < PORTS_WR; p++) begin
        for (int k = 0; k < NB; k++) begin
          if (be_eff[p][k] && (wr_addr_i[p] == rd_addr_i[i])) begin
            rd_d[i][k*8 +: 8] = wr_data_i[p][k*8 +: 8];
          end
        end
      end
`endif
    end
  end

  // Sequencer: INIT zeroes one address per cycle in all banks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      VRF_INIT: begin
        if (clear_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = VRF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      VRF_READY: begin
        if (clear_i) begin
          state_d = VRF_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = VRF_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= VRF_INIT;
      cnt_q   <= '0;
      coll_q  <= '0;
      for (int i = 0; i < PORTS_RD; i++) rd_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      for (int i = 0; i < PORTS_RD; i++) rd_q[i] <= rd_d[i];
    end
  end

  for (genvar b = 0; b < PORTS_WR; b++) begin : g_bank
    logic [AW-1:0]     raddr [NCOL];
    logic [PORT_W-1:0] rdata [NCOL];

    for (genvar c = 0; c < NCOL; c++) begin : g_col
      if (c < PORTS_RD) begin : g_rd
        assign raddr[c] = rd_addr_i[c];
      end else begin : g_lb
        // Loopback column j serves write port j, skipping this bank's own.
        localparam int unsigned J  = c - PORTS_RD;
        localparam int unsigned WP = (J < b) ? J : J + 1;
        assign raddr[c] = wr_addr_i[WP];
      end
      assign col_data[b][c] = rdata[c];
    end

    vproc_vregfile_bank #(
      .DEPTH  (DEPTH),
      .PORT_W (PORT_W),
      .N_RD   (NCOL)
    ) u_bank (
      .clk_i      (clk_i),
      .we_be_i    (be_eff[b]),
      .waddr_i    (wr_addr_i[b]),
      .wdata_i    (bank_wdata[b]),
      .raw_we_i   (state_q == VRF_INIT),
      .raw_addr_i (cnt_q),
      .raw_data_i ('0),
      .raddr_i    (raddr),
      .rdata_o    (rdata)
    );
  end

  assign ready_o   = in_ready;
  assign wr_coll_o = coll_q;
  assign rd_data_o = rd_q;

endmodule

// File: tb/tb_vproc_vregfile_mp.sv
// tb_vproc_vregfile_mp: self-checking bench for vproc_vregfile_mp with
// default parameters. A word-level memory model plus a sweep countdown
// predicts reads, collisions and ready_o; a monitor compares them.
module tb_vproc_vregfile_mp;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int NB    = 4;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int KCOLL = 100;
  localparam int KRDY  = 101;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic           ready;
  logic [AW-1:0]  wr_addr [NWR];
  logic [31:0]    wr_data [NWR];
  logic [NB-1:0]  wr_be   [NWR];
  logic [NWR-1:0] wr_we;
  logic [NWR-1:0] wr_coll;
  logic [AW-1:0]  rd_addr [NRD];
  logic [31:0]    rd_data [NRD];

  vproc_vregfile_mp dut (
    .clk_i        (clk),
    .async_rst_ni (rst_n),
    .clear_i      (clear),
    .ready_o      (ready),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_be_i      (wr_be),
    .wr_we_i      (wr_we),
    .wr_coll_o    (wr_coll),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          kind_q[$];
  int          addr_q[$];
  logic [31:0] exp_q[$];

  // Reference model: logical word contents and cycles of sweep remaining.
  logic [31:0] mem_m [DEPTH];
  int          sweep_left;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int addr, input logic [31:0] exp);
    kind_q.push_back(kind);
    addr_q.push_back(addr);
    exp_q.push_back(exp);
  endtask

  // Monitor: everything queued before an edge is visible just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        int k, a;
        logic [31:0] e;
        k = kind_q.pop_front();
        a = addr_q.pop_front();
        e = exp_q.pop_front();
        if (k < NRD)
          check($sformatf("rd%0d@%0d", k, a), rd_data[k], e);
        else if (k == KCOLL)
          check("wr_coll", {30'b0, wr_coll}, e);
        else
          check("ready", {31'b0, ready}, e);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_reads();
    for (int i = 0; i < NRD; i++) push(i, int'(rd_addr[i]), mem_m[rd_addr[i]]);
  endtask

  // Called just after a negedge with inputs set; models the next edge.
  task automatic step();
    logic           rb;
    logic [NWR-1:0] coll_e;
    rb = (sweep_left == 0);
`ifndef VPROC_VREGFILE_FWD_EN
    if (rb) push_reads();
`endif
    coll_e = '0;
    if (rb) begin
      for (int p = 0; p < NWR; p++)
        for (int q = p + 1; q < NWR; q++)
          if (wr_we[p] && wr_we[q] && wr_addr[p] == wr_addr[q] &&
              (wr_be[p] & wr_be[q]) != '0)
            coll_e[p] = 1'b1;
      // Applying ports in ascending order lets the highest port win.
      for (int p = 0; p < NWR; p++)
        if (wr_we[p])
          for (int k = 0; k < NB; k++)
            if (wr_be[p][k]) mem_m[wr_addr[p]][k*8 +: 8] = wr_data[p][k*8 +: 8];
    end
`ifdef VPROC_VREGFILE_FWD_EN
    if (rb) push_reads();
`endif
    push(KCOLL, 0, {30'b0, coll_e});
    if (clear) begin
      sweep_left = DEPTH;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0)
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    end
    push(KRDY, 0, {31'b0, sweep_left == 0});
    @(negedge clk);
  endtask

  task automatic idle();
    clear = 1'b0;
    wr_we = '0;
    for (int p = 0; p < NWR; p++) begin
      wr_addr[p] = AW'($urandom_range(DEPTH - 1, 0));
      wr_data[p] = $urandom;
      wr_be[p]   = NB'($urandom_range(15, 0));
    end
    for (int i = 0; i < NRD; i++) rd_addr[i] = AW'($urandom_range(DEPTH - 1, 0));
  endtask

  task automatic rand_inputs(input int arange);
    idle();
    for (int p = 0; p < NWR; p++) begin
      wr_addr[p] = AW'($urandom_range(arange - 1, 0));
      wr_we[p]   = 1'($urandom_range(1, 0));
    end
    for (int i = 0; i < NRD; i++) rd_addr[i] = AW'($urandom_range(arange - 1, 0));
  endtask

  task automatic write1(input int p, input int a, input logic [31:0] d,
                        input logic [NB-1:0] be);
    wr_we[p]   = 1'b1;
    wr_addr[p] = AW'(a);
    wr_data[p] = d;
    wr_be[p]   = be;
  endtask

  task automatic read_all();
    for (int base = 0; base < DEPTH; base += NRD) begin
      idle();
      for (int i = 0; i < NRD; i++) rd_addr[i] = AW'(base + i);
      step();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    rst_n = 1'b0;
    idle();
    sweep_left = DEPTH;
    #12;
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_coll", {30'b0, wr_coll}, 32'h0);
    for (int i = 0; i < NRD; i++) check($sformatf("reset_rd%0d", i), rd_data[i], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initial sweep with ignored write attempts, then everything reads 0.
    for (int c = 0; c < DEPTH + 4; c++) begin
      rand_inputs(DEPTH);
      step();
    end
    read_all();

    // Two ports, two addresses, read back two cycles later.
    idle();
    write1(0, 5, 32'hDEADBEEF, 4'hF);
    write1(1, 9, 32'h12345678, 4'hF);
    step();
    idle();
    step();
    idle();
    rd_addr[0] = 7'd5;
    rd_addr[1] = 7'd9;
    step();

    // Same-address collision: port 1 takes the low two bytes.
    idle();
    write1(0, 7, 32'hAAAAAAAA, 4'hF);
    write1(1, 7, 32'h55555555, 4'h3);
    step();
    idle();
    rd_addr[0] = 7'd7;
    step();

    // Read and write of the same address in one cycle.
    idle();
    write1(0, 3, 32'h11111111, 4'hF);
    rd_addr[2] = 7'd3;
    step();
    idle();
    rd_addr[2] = 7'd3;
    step();

    // Random traffic: dense addresses for collisions, then full range.
    for (int c = 0; c < 200; c++) begin
      rand_inputs(8);
      step();
    end
    for (int c = 0; c < 200; c++) begin
      rand_inputs(DEPTH);
      step();
    end

    // Fill 10 addresses, clear, attempt writes during the sweep.
    for (int i = 0; i < 10; i++) begin
      idle();
      write1(i % NWR, 20 + i, $urandom | 32'h1, 4'hF);
      step();
    end
    idle();
    for (int i = 0; i < NRD; i++) rd_addr[i] = AW'(20 + i);
    clear = 1'b1;
    write1(1, 40, 32'hCAFEF00D, 4'hF);
    step();
    for (int c = 0; c < DEPTH + 2; c++) begin
      rand_inputs(DEPTH);
      step();
    end
    read_all();

    // Reset asserted 60 cycles into a sweep.
    for (int i = 0; i < NRD; i++) begin
      idle();
      write1(0, 100 + i, 32'hF0F0F0F0 ^ i, 4'hF);
      step();
    end
    idle();
    clear = 1'b1;
    step();
    for (int c = 0; c < 60; c++) begin
      idle();
      for (int i = 0; i < NRD; i++) rd_addr[i] = AW'(100 + i);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", {31'b0, ready}, 32'h0);
    for (int i = 0; i < NRD; i++) check($sformatf("midreset_rd%0d", i), rd_data[i], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_left = DEPTH;
    for (int c = 0; c < DEPTH + 2; c++) begin
      rand_inputs(DEPTH);
      step();
    end
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
